aes_spi_slave: RTL and testbench

//  SPI-slave end of the AES test link; the peer of SPI_Master. Receives an opcode, a 128-bit block and a
//  128/192/256-bit key over SPI mode 0, starts the AES core and latches its 128-bit result.
//  The result is returned on a separate READ frame. Sits between the SPI pins and the AES core.

---
 rtl/aes_spi_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_aes_spi_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_slave.sv
// ---------------------------------------------------------------------------
// aes_spi_slave
//   SPI-slave (mode 0) end of the AES test link. A frame starts with an opcode
//   byte:
//     [7:6] 01 = LOAD_RUN, 10 = READ, other = ignored
//     [5]   1 = encrypt, 0 = decrypt
//     [1:0] key size: 00 = 128, 01 = 192, 10 = 256 bits
//   LOAD_RUN then carries the 128-bit block and the key, MSB first. When
//   chip-select rises, the block, key, key size and direction are loaded into
//   the core-facing registers and the core is started. READ returns a status
//   byte {result_valid, busy, overrun, bad_nk, par_err, 3'b0} followed by the
//   latched 128-bit result.
//
//   Optional feature: define AES_SPI_SLV_PARITY_EN to add one even-parity bit
//   after the key of a LOAD_RUN frame. The parity covers opcode, data and key.
//   A parity mismatch discards the frame and sets par_err. When the macro is
//   undefined, there is no parity bit and par_err is always 0.
//
// Ports
//   clk          system clock (>= 4x sclk)
//   rst          asynchronous reset, active low
//   sclk/cs_n    SPI clock (idle low) and chip select (active low)
//   mosi/miso    serial data in / out, MSB first; miso is 0 when idle
//   core_start   one-clk launch pulse to the AES core
//   core_enc     1 = encrypt, 0 = decrypt
//   core_nk      key size code for the core
//   core_data    block to the core
//   core_key     key to the core; shorter keys are left-justified
//   core_done    one-clk completion pulse from the core
//   core_result  core output, captured on core_done
//   busy         a start was issued and core_done has not been seen yet
//   result_valid the result register was loaded and no start has followed
//   err          OR of the sticky error bits
// ---------------------------------------------------------------------------
module aes_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 128,
  parameter int KEY_W       = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              core_start,
  output logic              core_enc,
  output logic [1:0]        core_nk,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              result_valid,
  output logic              err
);

`ifdef AES_SPI_SLV_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CNT_W = $clog2(DATA_W + KEY_W + 2);
  localparam int TX_W  = DATA_W + 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_RX    = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_TX    = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  // Index of the last key bit within the RX phase (the data bits come first).
  function automatic logic [CNT_W-1:0] key_last(input logic [1:0] nk);
    int unsigned n;
    case (nk)
      2'b00:   n = DATA_W + 128;
      2'b01:   n = DATA_W + 192;
      default: n = DATA_W + KEY_W;
    endcase
    return CNT_W'(n - 1);
  endfunction

  // Left-justify a key that was shifted in from the LSB end.
  function automatic logic [KEY_W-1:0] justify_key(input logic [KEY_W-1:0] k,
                                                   input logic [1:0] nk);
    case (nk)
      2'b00:   return k << (KEY_W - 128);
      2'b01:   return k << (KEY_W - 192);
      default: return k;
    endcase
  endfunction

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Frame state, shift registers and core-facing registers
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_kind_q, op_kind_d;
  logic              op_enc_q, op_enc_d;
  logic [1:0]        op_nk_q, op_nk_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [KEY_W-1:0]  key_sh_q, key_sh_d;
  logic [TX_W-1:0]   tx_sh_q, tx_sh_d;
  logic              miso_q, miso_d;
  logic              start_q, start_d;
  logic              enc_q, enc_d;
  logic [1:0]        nk_q, nk_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic [KEY_W-1:0]  ckey_q, ckey_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              rv_q, rv_d;
  logic              overrun_q, overrun_d;
  logic              bad_nk_q, bad_nk_d;
  logic              rd_full_q, rd_full_d;
  logic              par_err_w;
`ifdef AES_SPI_SLV_PARITY_EN
  logic              par_q, par_d;
  logic              par_err_q, par_err_d;
  assign par_err_w = par_err_q;
`else
  assign par_err_w = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_kind_d = op_kind_q;
    op_enc_d  = op_enc_q;
    op_nk_d   = op_nk_q;
    data_sh_d = data_sh_q;
    key_sh_d  = key_sh_q;
    tx_sh_d   = tx_sh_q;
    miso_d    = miso_q;
    start_d   = 1'b0;
    enc_d     = enc_q;
    nk_d      = nk_q;
    cdata_d   = cdata_q;
    ckey_d    = ckey_q;
    result_d  = result_q;
    busy_d    = busy_q;
    rv_d      = rv_q;
    overrun_d = overrun_q;
    bad_nk_d  = bad_nk_q;
    rd_full_d = rd_full_q;
`ifdef AES_SPI_SLV_PARITY_EN
    par_d     = par_q;
    par_err_d = par_err_q;
`endif

    // Completion is applied first so a same-cycle commit below overrides it.
    if (core_done && busy_q) begin
      result_d = core_result;
      busy_d   = 1'b0;
      rv_d     = 1'b1;
    end

    if (cs_rise) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      // Only a LOAD_RUN frame that received all its bits reaches DONE.
      if (state_q == S_DONE) begin
        if (op_nk_q == 2'b11) begin
          bad_nk_d = 1'b1;
        end
`ifdef AES_SPI_SLV_PARITY_EN
        else if (par_q) begin
          par_err_d = 1'b1;
        end
`endif
        else if (busy_q && !core_done) begin
          overrun_d = 1'b1;
        end else begin
          cdata_d = data_sh_q;
          ckey_d  = justify_key(key_sh_q, op_nk_q);
          nk_d    = op_nk_q;
          enc_d   = op_enc_q;
          start_d = 1'b1;
          busy_d  = 1'b1;
          rv_d    = 1'b0;
        end
      end
      if (rd_full_q) begin
        overrun_d = 1'b0;
        bad_nk_d  = 1'b0;
`ifdef AES_SPI_SLV_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
    end else if (cs_fall && (state_q == S_IDLE)) begin
      state_d   = S_CMD;
      cnt_d     = '0;
      rd_full_d = 1'b0;
`ifdef AES_SPI_SLV_PARITY_EN
      par_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        S_CMD: begin
          if (sclk_rise) begin
`ifdef AES_SPI_SLV_PARITY_EN
            par_d = par_q ^ mosi_s;
`endif
            // Only the opcode fields that are used get stored.
            case (cnt_q[2:0])
              3'd0:    op_kind_d[1] = mosi_s;
              3'd1:    op_kind_d[0] = mosi_s;
              3'd2:    op_enc_d     = mosi_s;
              3'd6:    op_nk_d[1]   = mosi_s;
              3'd7:    op_nk_d[0]   = mosi_s;
              default: ;
            endcase
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              case (op_kind_q)
                2'b01: state_d = S_RX;
                2'b10: begin
                  state_d = S_TX;
                  tx_sh_d = {rv_q, busy_q, overrun_q, bad_nk_q, par_err_w,
                             3'b000, result_q};
                end
                default: state_d = S_DRAIN;
              endcase
            end
          end
        end
        S_RX: begin
          if (sclk_rise) begin
`ifdef AES_SPI_SLV_PARITY_EN
            par_d = par_q ^ mosi_s;
`endif
            if (cnt_q < CNT_W'(DATA_W)) begin
              data_sh_d = {data_sh_q[DATA_W-2:0], mosi_s};
            end else if (cnt_q <= key_last(op_nk_q)) begin
              key_sh_d = {key_sh_q[KEY_W-2:0], mosi_s};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == key_last(op_nk_q) + CNT_W'(PAR_BITS)) begin
              state_d = S_DONE;
            end
          end
        end
        S_TX: begin
          if (sclk_fall) begin
            miso_d  = tx_sh_q[TX_W-1];
            tx_sh_d = {tx_sh_q[TX_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TX_W - 1)) begin
              state_d   = S_DRAIN;
              rd_full_d = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (sclk_fall) begin
            miso_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_kind_q <= '0;
      op_enc_q  <= 1'b0;
      op_nk_q   <= '0;
      data_sh_q <= '0;
      key_sh_q  <= '0;
      tx_sh_q   <= '0;
      miso_q    <= 1'b0;
      start_q   <= 1'b0;
      enc_q     <= 1'b0;
      nk_q      <= '0;
      cdata_q   <= '0;
      ckey_q    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
      overrun_q <= 1'b0;
      bad_nk_q  <= 1'b0;
      rd_full_q <= 1'b0;
`ifdef AES_SPI_SLV_PARITY_EN
      par_q     <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_kind_q <= op_kind_d;
      op_enc_q  <= op_enc_d;
      op_nk_q   <= op_nk_d;
      data_sh_q <= data_sh_d;
      key_sh_q  <= key_sh_d;
      tx_sh_q   <= tx_sh_d;
      miso_q    <= miso_d;
      start_q   <= start_d;
      enc_q     <= enc_d;
      nk_q      <= nk_d;
      cdata_q   <= cdata_d;
      ckey_q    <= ckey_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
      overrun_q <= overrun_d;
      bad_nk_q  <= bad_nk_d;
      rd_full_q <= rd_full_d;
`ifdef AES_SPI_SLV_PARITY_EN
      par_q     <= par_d;
      par_err_q <= par_err_d;
`endif
    end
  end

  assign miso         = miso_q;
  assign core_start   = start_q;
  assign core_enc     = enc_q;
  assign core_nk      = nk_q;
  assign core_data    = cdata_q;
  assign core_key     = ckey_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign err          = overrun_q | bad_nk_q | par_err_w;

endmodule

// File: tb/tb_aes_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_aes_spi_slave
//   Directed bench for aes_spi_slave. An SPI master is driven from tasks
//   (sclk = clk/10). The AES core is stood in for by hand-issued core_done
//   pulses carrying known results.
// ---------------------------------------------------------------------------
module tb_aes_spi_slave;
  logic         clk = 1'b0;
  logic         rst, sclk, cs_n, mosi, miso;
  logic         core_start, core_enc, core_done, busy, result_valid, err;
  logic [1:0]   core_nk;
  logic [127:0] core_data, core_result;
  logic [255:0] core_key;

  int vectors     = 0;
  int miscompares = 0;
  int start_cnt   = 0;

`ifdef AES_SPI_SLV_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  localparam logic [127:0] D2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] R2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K3 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] R3 = 128'h00112233445566778899aabbccddeeff;

  aes_spi_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .core_start(core_start), .core_enc(core_enc), .core_nk(core_nk),
    .core_data(core_data), .core_key(core_key), .core_done(core_done),
    .core_result(core_result), .busy(busy), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Each clock that core_start is high adds one.
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  function automatic int klen(input logic [1:0] nk);
    case (nk)
      2'b00:   return 128;
      2'b01:   return 192;
      default: return 256;
    endcase
  endfunction

  function automatic logic [399:0] mk_load(input logic enc, input logic [1:0] nk,
                                           input logic [127:0] d, input logic [255:0] k);
    logic [399:0] v;
    logic [7:0]   op;
    op = {2'b01, enc, 3'b000, nk};
    v = '0;
    v[399:392] = op;
    v[391:264] = d;
    v[263:8]   = k;
    if (PB == 1) v[263 - klen(nk)] = ^{op, d, k};
    return v;
  endfunction

  task automatic spi_bits(input int n, input logic [399:0] v, output logic [135:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = v[399 - i];
      #50 sclk = 1'b1;
      rx = {rx[134:0], miso};
      #50 sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic frame(input int n, input logic [399:0] v, output logic [135:0] rx);
    cs_n = 1'b0;
    #100;
    spi_bits(n, v, rx);
    #50 cs_n = 1'b1;
    #150;
  endtask

  task automatic read_frame(output logic [135:0] rx);
    logic [399:0] v;
    v = '0;
    v[399:392] = 8'h80;
    frame(144, v, rx);
  endtask

  task automatic pulse_done(input logic [127:0] r);
    @(negedge clk);
    core_result = r;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
    #20;
  endtask

  task automatic test_reset;
    logic [135:0] rx;
    rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    core_done = 1'b0; core_result = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({miso, core_start, core_enc, busy, result_valid, err, core_nk} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {miso, core_start, core_enc, busy, result_valid, err, core_nk});
    end
    vectors++;
    if ({core_data, core_key} !== 384'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h expected all zero", core_data, core_key);
    end
    rst = 1'b1;
    #100;
    // Reset in the middle of the data phase of a LOAD_RUN.
    cs_n = 1'b0;
    #100;
    spi_bits(60, mk_load(1'b1, 2'b00, D2, K2), rx);
    rst = 1'b0;
    #30;
    vectors++;
    if ({miso, core_start, busy, result_valid, err, core_nk} !== 7'h00) begin
      miscompares++;
      $display("FAIL reset_midrx: got %b expected 0000000",
               {miso, core_start, busy, result_valid, err, core_nk});
    end
    cs_n = 1'b1;
    #50 rst = 1'b1;
    #100;
    vectors++;
    if (start_cnt !== 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: starts %0d err %b expected 0 0", start_cnt, err);
    end
  endtask

  task automatic test_load_enc;
    logic [135:0] rx;
    int s0;
    s0 = start_cnt;
    frame(136 + 128 + PB, mk_load(1'b1, 2'b00, D2, K2), rx);
    vectors++;
    if (start_cnt !== s0 + 1) begin
      miscompares++;
      $display("FAIL enc_start: got %0d pulses expected 1", start_cnt - s0);
    end
    vectors++;
    if ({core_enc, core_nk, busy, result_valid} !== 5'b10010) begin
      miscompares++;
      $display("FAIL enc_ctrl: got %b expected 10010", {core_enc, core_nk, busy, result_valid});
    end
    vectors++;
    if (core_data !== D2 || core_key !== K2) begin
      miscompares++;
      $display("FAIL enc_shadow: got %h/%h expected %h/%h", core_data, core_key, D2, K2);
    end
    pulse_done(R2);
    vectors++;
    if ({busy, result_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL enc_done: got %b expected 01", {busy, result_valid});
    end
    read_frame(rx);
    vectors++;
    if (rx !== {8'h80, R2}) begin
      miscompares++;
      $display("FAIL enc_read: got %h expected %h", rx, {8'h80, R2});
    end
    vectors++;
    if (miso !== 1'b0 || result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL enc_after_read: miso %b rv %b expected 0 1", miso, result_valid);
    end
  endtask

  task automatic test_load_dec;
    logic [135:0] rx;
    int s0;
    s0 = start_cnt;
    frame(136 + 192 + PB, mk_load(1'b0, 2'b01, D3, K3), rx);
    vectors++;
    if (start_cnt !== s0 + 1 || core_enc !== 1'b0 || core_nk !== 2'b01) begin
      miscompares++;
      $display("FAIL dec_ctrl: pulses %0d enc %b nk %b expected 1 0 01",
               start_cnt - s0, core_enc, core_nk);
    end
    vectors++;
    if (core_data !== D3 || core_key !== K3) begin
      miscompares++;
      $display("FAIL dec_shadow: got %h/%h expected %h/%h", core_data, core_key, D3, K3);
    end
    pulse_done(R3);
    read_frame(rx);
    vectors++;
    if (rx !== {8'h80, R3}) begin
      miscompares++;
      $display("FAIL dec_read: got %h expected %h", rx, {8'h80, R3});
    end
  endtask

  task automatic test_overrun;
    logic [135:0] rx;
    int s1;
    frame(136 + 128 + PB, mk_load(1'b1, 2'b00, D2, K2), rx);
    s1 = start_cnt;
    frame(136 + 256 + PB, mk_load(1'b0, 2'b10, D3, K3), rx);
    vectors++;
    if (start_cnt !== s1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_flag: pulses %0d err %b expected 0 1", start_cnt - s1, err);
    end
    vectors++;
    if (core_data !== D2 || core_nk !== 2'b00 || core_enc !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_untouched: data %h nk %b enc %b expected %h 00 1",
               core_data, core_nk, core_enc, D2);
    end
    read_frame(rx);
    vectors++;
    if (rx !== {8'h60, R3}) begin
      miscompares++;
      $display("FAIL ovr_read: got %h expected %h", rx, {8'h60, R3});
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear: err %b expected 0", err);
    end
    pulse_done(R2);
  endtask

  task automatic test_abort_badnk;
    logic [135:0] rx;
    int s0;
    s0 = start_cnt;
    frame(8 + 70, mk_load(1'b0, 2'b01, D3, K3), rx);
    vectors++;
    if (start_cnt !== s0 || core_data !== D2 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: pulses %0d data %h err %b expected 0 %h 0",
               start_cnt - s0, core_data, err, D2);
    end
    frame(136 + 256 + PB, mk_load(1'b1, 2'b11, D3, K2), rx);
    vectors++;
    if (start_cnt !== s0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL badnk_flag: pulses %0d err %b expected 0 1", start_cnt - s0, err);
    end
    read_frame(rx);
    vectors++;
    if (rx !== {8'h90, R2}) begin
      miscompares++;
      $display("FAIL badnk_read: got %h expected %h", rx, {8'h90, R2});
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL badnk_clear: err %b expected 0", err);
    end
  endtask

`ifdef AES_SPI_SLV_PARITY_EN
  task automatic test_parity;
    logic [135:0] rx;
    logic [399:0] v;
    int s0;
    s0 = start_cnt;
    v = mk_load(1'b1, 2'b00, D3, K2);
    v[263 - 128] = ~v[263 - 128];
    frame(136 + 128 + 1, v, rx);
    vectors++;
    if (start_cnt !== s0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL par_bad: pulses %0d err %b expected 0 1", start_cnt - s0, err);
    end
    read_frame(rx);
    vectors++;
    if (rx[135:128] !== 8'h88) begin
      miscompares++;
      $display("FAIL par_status: got %h expected 88", rx[135:128]);
    end
    frame(136 + 128 + 1, mk_load(1'b1, 2'b00, D3, K2), rx);
    vectors++;
    if (start_cnt !== s0 + 1 || core_data !== D3 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL par_good: pulses %0d data %h err %b expected 1 %h 0",
               start_cnt - s0, core_data, err, D3);
    end
    pulse_done(R3);
  endtask
`endif

  task automatic test_reset_midrun;
    logic [135:0] rx;
    int s0;
    s0 = start_cnt;
    frame(136 + 128 + PB, mk_load(1'b1, 2'b00, D2, K2), rx);
    vectors++;
    if (start_cnt !== s0 + 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_start: pulses %0d busy %b expected 1 1", start_cnt - s0, busy);
    end
    rst = 1'b0;
    #30 rst = 1'b1;
    #50;
    vectors++;
    if ({busy, result_valid, err} !== 3'b000 || core_data !== 128'h0) begin
      miscompares++;
      $display("FAIL run_reset: flags %b data %h expected 000 0",
               {busy, result_valid, err}, core_data);
    end
    pulse_done(R3);
    vectors++;
    if ({busy, result_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL late_done: got %b expected 00", {busy, result_valid});
    end
    read_frame(rx);
    vectors++;
    if (rx !== 136'h0) begin
      miscompares++;
      $display("FAIL empty_read: got %h expected 0", rx);
    end
  endtask

  initial begin
    test_reset();
    test_load_enc();
    test_load_dec();
    test_overrun();
    test_abort_badnk();
`ifdef AES_SPI_SLV_PARITY_EN
    test_parity();
`endif
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
